// File: rtl/cic_comb_decimator.sv
// Decimating comb section of the CIC filter, downstream of the time-multiplexed integrator.
// Keeps every R-th integrator sample per channel (R = decim_i + 1) and runs it through STAGES
// first-difference sections, one stage per cycle on a shared subtractor. The result leaves
// on a valid/ready handshake.
//
// Ports:
//   clk_i, rstn_i     clock, asynchronous active-low reset
//   en_i, clr_i       sample enable, synchronous clear of all state (highest priority)
//   decim_i           decimation ratio minus one, shared by all four channels
//   valid_i/ch_i/data_i  integrator sample, its channel and accumulator value
//   valid_o/ready_i   output handshake; ch_o/data_o hold the comb result
//   busy_o            computation or output in progress
//   ovf_o             sticky: a kept sample was dropped while busy
module cic_comb_decimator #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 5,
  parameter int unsigned CNT_W  = 10
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] decim_i,
  input  logic             valid_i,
  input  logic [1:0]       ch_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [1:0]       ch_o,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o,
  output logic             ovf_o
);

  localparam int unsigned K_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {StIdle, StComb, StOut} state_e;

  state_e           r_state;
  state_e           w_state_next;

  logic [CNT_W-1:0] r_cnt [4];
  logic [WIDTH-1:0] r_dly [4][STAGES];
  logic [WIDTH-1:0] r_x;
  logic [1:0]       r_ch;
  logic [K_W-1:0]   r_k;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_ch_out;
  logic             r_ovf;

  logic             w_sample;
  logic             w_kept;
  logic             w_last;
  logic [WIDTH-1:0] w_dly_cur;
  logic [WIDTH-1:0] w_diff;

  assign w_sample  = valid_i & en_i;
  assign w_kept    = w_sample & (r_cnt[ch_i] == decim_i);
  assign w_last    = (r_k == K_W'(STAGES - 1));
  assign w_dly_cur = r_dly[r_ch][r_k];
  // Modulo-2^WIDTH wrap is what keeps the integrator/comb pair exact.
  assign w_diff    = r_x - w_dly_cur;

  // FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_kept) w_state_next = StComb;
      StComb:  if (w_last) w_state_next = StOut;
      StOut:   if (ready_i) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (clr_i) begin
      w_state_next = StIdle;
    end
  end

  // Per-channel decimation counters; they advance even when the kept sample is dropped.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < 4; c++) r_cnt[c] <= '0;
    end else if (clr_i) begin
      for (int c = 0; c < 4; c++) r_cnt[c] <= '0;
    end else if (w_sample) begin
      if (w_kept) begin
        r_cnt[ch_i] <= '0;
      end else begin
        r_cnt[ch_i] <= r_cnt[ch_i] + 1'b1;
      end
    end
  end

  // Comb datapath: one stage per cycle, delay line updated with the stage input.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_x      <= '0;
      r_ch     <= '0;
      r_k      <= '0;
      r_data   <= '0;
      r_ch_out <= '0;
      for (int c = 0; c < 4; c++) begin
        for (int s = 0; s < STAGES; s++) r_dly[c][s] <= '0;
      end
    end else if (clr_i) begin
      // data_o/ch_o keep their last values; valid_o drops via the FSM.
      r_x  <= '0;
      r_ch <= '0;
      r_k  <= '0;
      for (int c = 0; c < 4; c++) begin
        for (int s = 0; s < STAGES; s++) r_dly[c][s] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_kept) begin
            r_x  <= data_i;
            r_ch <= ch_i;
            r_k  <= '0;
          end
        end
        StComb: begin
          r_x              <= w_diff;
          r_dly[r_ch][r_k] <= r_x;
          r_k              <= w_last ? '0 : r_k + K_W'(1);
          if (w_last) begin
            r_data   <= w_diff;
            r_ch_out <= r_ch;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky overflow: kept sample arrives while not idle (no bypass out of StOut).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ovf <= 1'b0;
    end else if (clr_i) begin
      r_ovf <= 1'b0;
    end else if (w_kept && (r_state != StIdle)) begin
      r_ovf <= 1'b1;
    end
  end

  assign valid_o = (r_state == StOut);
  assign busy_o  = (r_state != StIdle);
  assign data_o  = r_data;
  assign ch_o    = r_ch_out;
  assign ovf_o   = r_ovf;

endmodule
